// File: rtl/rvbug_pkg.sv
// Shared types and constants for the rvcore memory sequencer: window FSM
// encodings, the fetch-timeout filler instruction and a word-align helper.
package rvbug_pkg;

  typedef enum logic [2:0] {
    ST_CAPTURE = 3'd0,
    ST_D_REQ   = 3'd1,
    ST_D_RSP   = 3'd2,
    ST_I_REQ   = 3'd3,
    ST_I_RSP   = 3'd4,
    ST_RELEASE = 3'd5
  } arb_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Handshake watchdog: down-counter reloaded on every wait-state entry, flags
// expiry at terminal count. Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic active_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= LOAD_VAL;
    end else if (load_i) begin
      cnt_q <= LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Terminal count is reached in the TIMEOUT_CYCLES-th cycle spent in a state.
  assign expired_o = active_i && (cnt_q == '0);

endmodule

// File: rtl/mem_seq_arb.sv
// Window sequencer sharing one request/response memory between rvcore fetch and
// data access. Optional handshake watchdog enabled by macro MEM_ARB_TIMEOUT_EN.
//
// state      | meaning
// -----------+--------------------------------------------------
// CAPTURE    | latch core request fields, pick data or fetch path
// D_REQ      | present load/store request, wait for ready
// D_RSP      | wait for data response (load result into d_pend)
// I_REQ      | present fetch request, wait for ready
// I_RSP      | wait for fetch response (into core_irdata_o)
// RELEASE    | stall low for one cycle, pipeline advances
module mem_seq_arb
  import rvbug_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int XBYTES = XLEN / 8
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              core_stall_o,
  input  logic [XLEN-1:0]   core_iaddr_i,
  output logic [ILEN-1:0]   core_irdata_o,
  input  logic [XLEN-1:0]   core_daddr_i,
  input  logic              core_dren_i,
  input  logic              core_dwvalid_i,
  input  logic [XLEN-1:0]   core_dwdata_i,
  input  logic [XBYTES-1:0] core_dwstrb_i,
  output logic [XLEN-1:0]   core_drdata_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [XLEN-1:0]   mem_req_addr_o,
  output logic              mem_req_we_o,
  output logic [XLEN-1:0]   mem_req_wdata_o,
  output logic [XBYTES-1:0] mem_req_wstrb_o,
  input  logic              mem_rsp_valid_i,
  input  logic [XLEN-1:0]   mem_rsp_rdata_i,
  output logic              err_o
);

  arb_state_e        state_q, state_d;
  logic [XLEN-1:0]   iaddr_q, daddr_q, dwdata_q, d_pend_q, drdata_q;
  logic [XLEN-1:0]   i_align, d_align;
  logic [XBYTES-1:0] dwstrb_q;
  logic              dren_q, dwvalid_q;
  logic [ILEN-1:0]   irdata_q;
  logic              req_hs, tmo_fire;

  if (XLEN == 32) begin : g_align32
    assign i_align = word_align(core_iaddr_i);
    assign d_align = word_align(core_daddr_i);
  end else begin : g_align_n
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    assign i_align = core_iaddr_i & ALIGN_MASK;
    assign d_align = core_daddr_i & ALIGN_MASK;
  end

  assign req_hs = mem_req_valid_o && mem_req_ready_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CAPTURE: state_d = (core_dren_i || core_dwvalid_i) ? ST_D_REQ : ST_I_REQ;
      ST_D_REQ: begin
        if (req_hs)        state_d = ST_D_RSP;
        else if (tmo_fire) state_d = ST_I_REQ;
      end
      ST_D_RSP: begin
        if (mem_rsp_valid_i || tmo_fire) state_d = ST_I_REQ;
      end
      ST_I_REQ: begin
        if (req_hs)        state_d = ST_I_RSP;
        else if (tmo_fire) state_d = ST_RELEASE;
      end
      ST_I_RSP: begin
        if (mem_rsp_valid_i || tmo_fire) state_d = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_CAPTURE;
      default:    state_d = ST_CAPTURE;
    endcase
  end

  assign core_stall_o    = (state_q != ST_RELEASE);
  assign mem_req_valid_o = (state_q == ST_D_REQ) || (state_q == ST_I_REQ);
  assign mem_req_addr_o  = (state_q == ST_D_REQ) ? daddr_q : iaddr_q;
  assign mem_req_we_o    = (state_q == ST_D_REQ) && dwvalid_q;
  assign mem_req_wdata_o = dwdata_q;
  assign mem_req_wstrb_o = mem_req_we_o ? dwstrb_q : '0;
  assign core_irdata_o   = irdata_q;
  assign core_drdata_o   = drdata_q;

`ifdef MEM_ARB_TIMEOUT_EN
  logic wait_st, tmo_load, tmo_expired, progress, err_q;

  assign wait_st  = state_q inside {ST_D_REQ, ST_D_RSP, ST_I_REQ, ST_I_RSP};
  assign tmo_load = !wait_st || (state_d != state_q);
  assign progress = req_hs ||
                    (((state_q == ST_D_RSP) || (state_q == ST_I_RSP)) && mem_rsp_valid_i);
  // A handshake landing on the expiry cycle still counts as progress.
  assign tmo_fire = tmo_expired && !progress;

  mem_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (tmo_load),
    .active_i (wait_st),
    .expired_o(tmo_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i)         err_q <= 1'b0;
    else if (tmo_fire) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign tmo_fire = 1'b0;
  assign err_o    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_CAPTURE;
      iaddr_q   <= '0;
      daddr_q   <= '0;
      dren_q    <= 1'b0;
      dwvalid_q <= 1'b0;
      dwdata_q  <= '0;
      dwstrb_q  <= '0;
      d_pend_q  <= '0;
      drdata_q  <= '0;
      irdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CAPTURE) begin
        iaddr_q   <= i_align;
        daddr_q   <= d_align;
        dren_q    <= core_dren_i;
        dwvalid_q <= core_dwvalid_i;
        dwdata_q  <= core_dwdata_i;
        dwstrb_q  <= core_dwstrb_i;
      end
      if ((state_q == ST_D_RSP) && mem_rsp_valid_i && dren_q && !dwvalid_q)
        d_pend_q <= mem_rsp_rdata_i;
      if ((state_q == ST_I_RSP) && mem_rsp_valid_i)
        irdata_q <= mem_rsp_rdata_i[ILEN-1:0];
      // Load result moves to the core as the window closes, held through the next one.
      if (state_q == ST_RELEASE)
        drdata_q <= d_pend_q;
`ifdef MEM_ARB_TIMEOUT_EN
      if (tmo_fire) begin
        if ((state_q == ST_I_REQ) || (state_q == ST_I_RSP)) irdata_q <= NOP_INSTR;
        else if (dren_q && !dwvalid_q)                       d_pend_q <= '0;
      end
`endif
    end
  end

endmodule
